// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcode/state types and sizing helper for seq_alu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_EQ   = 3'b010,
    OP_HALF = 3'b011,
    OP_MUL  = 3'b100,
    OP_DIV  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width for a given operand width.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_iter.sv
// ============================================================================
// Module  : seq_alu_iter
// Brief   : Shared shift-add multiply / restoring divide iteration datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 divMode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   nextResult
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_opnd;
  logic             r_isDiv;

  logic [WIDTH-1:0] w_srcAcc;
  logic [WIDTH-1:0] w_srcSh;
  logic [WIDTH-1:0] w_srcOpnd;
  logic             w_isDiv;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_nextAcc;
  logic [WIDTH-1:0] w_nextSh;

  // A load performs the first iteration straight from the operand inputs.
  assign w_srcAcc  = load ? '0      : r_acc;
  assign w_srcSh   = load ? a       : r_sh;
  assign w_srcOpnd = load ? b       : r_opnd;
  assign w_isDiv   = load ? divMode : r_isDiv;

  always_comb begin
    w_mulSum   = {1'b0, w_srcAcc} + (w_srcSh[0] ? {1'b0, w_srcOpnd} : {(WIDTH+1){1'b0}});
    w_remShift = {w_srcAcc, w_srcSh[WIDTH-1]};
    w_trial    = w_remShift - {1'b0, w_srcOpnd};
    w_fits     = (w_remShift >= {1'b0, w_srcOpnd});
    if (w_isDiv) begin
      w_nextAcc = w_fits ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0];
      w_nextSh  = {w_srcSh[WIDTH-2:0], w_fits};
    end else begin
      w_nextAcc = w_mulSum[WIDTH:1];
      w_nextSh  = {w_mulSum[0], w_srcSh[WIDTH-1:1]};
    end
  end

  assign nextResult = {w_nextAcc, w_nextSh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_sh    <= '0;
      r_opnd  <= '0;
      r_isDiv <= 1'b0;
    end else if (load) begin
      r_acc   <= w_nextAcc;
      r_sh    <= w_nextSh;
      r_opnd  <= b;
      r_isDiv <= divMode;
    end else if (step) begin
      r_acc   <= w_nextAcc;
      r_sh    <= w_nextSh;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module  : seq_alu
// Brief   : Handshaked ALU: single-cycle add/sub/eq/half, iterative mul/div.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   q,
  output logic                 carry,
  output logic                 borrow,
  output logic                 zero,
  output logic                 dbz,
  output logic                 illegal
);

  localparam int CW = countWidth(WIDTH);
  // The accepting edge already runs the first iteration.
  localparam logic [CW-1:0] C_ITERS_LEFT = CW'(WIDTH - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [CW-1:0]       r_cnt;
  op_t                 w_op;
  logic                w_accept;
  logic                w_longOp;
  logic                w_lastIter;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_scQ;
  logic                w_scCarry;
  logic                w_scBorrow;
  logic                w_scDbz;
  logic                w_scIllegal;
  logic [2*WIDTH-1:0]  w_iterRes;

  assign w_op       = op_t'(op);
  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_longOp   = (w_op == OP_MUL) || ((w_op == OP_DIV) && (b != '0));
  assign w_lastIter = (r_state == ST_BUSY) && (r_cnt == CW'(1));
  assign w_sum      = {1'b0, a} + {1'b0, b};

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_accept && w_longOp),
    .step       (r_state == ST_BUSY),
    .divMode    (w_op == OP_DIV),
    .a          (a),
    .b          (b),
    .nextResult (w_iterRes)
  );

  always_comb begin
    w_scQ       = '0;
    w_scCarry   = 1'b0;
    w_scBorrow  = 1'b0;
    w_scDbz     = 1'b0;
    w_scIllegal = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_scQ[WIDTH:0] = w_sum;
        w_scCarry      = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_scQ[WIDTH-1:0] = a - b;
        w_scBorrow       = (a < b);
      end
      OP_EQ:   w_scQ[WIDTH-1:0] = ~(a ^ b);
      OP_HALF: w_scQ[WIDTH-1:0] = a >> 1;
      OP_DIV: begin
        // Only reached with b == 0: remainder = a, quotient saturates.
        w_scQ   = {a, {WIDTH{1'b1}}};
        w_scDbz = 1'b1;
      end
      OP_MUL:  w_scQ = '0;
      default: w_scIllegal = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = w_longOp ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_lastIter) w_nextState = ST_DONE;
      ST_DONE: if (out_ready) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      q       <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      zero    <= 1'b0;
      dbz     <= 1'b0;
      illegal <= 1'b0;
    end else if (w_accept && w_longOp) begin
      r_cnt <= C_ITERS_LEFT;
    end else if (w_accept) begin
      q       <= w_scQ;
      carry   <= w_scCarry;
      borrow  <= w_scBorrow;
      zero    <= (w_scQ == '0);
      dbz     <= w_scDbz;
      illegal <= w_scIllegal;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_lastIter) begin
        q       <= w_iterRes;
        carry   <= 1'b0;
        borrow  <= 1'b0;
        zero    <= (w_iterRes == '0);
        dbz     <= 1'b0;
        illegal <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module  : tb_seq_alu
// Brief   : Self-checking bench for seq_alu (WIDTH=3), directed plus random.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] q;
  logic           carry, borrow, zero, dbz, illegal;

  int nChecks = 0;
  int nPass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .carry     (carry),
    .borrow    (borrow),
    .zero      (zero),
    .dbz       (dbz),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    int q;
    int flags;   // {carry, borrow, zero, dbz, illegal}
    int lat;
  } expect_t;

  // Reference behaviour straight from the arithmetic definitions.
  function automatic expect_t model(input int o, input int x, input int y);
    expect_t e;
    int m;
    int c, br, d, il;
    m = 1 << W;
    c = 0; br = 0; d = 0; il = 0;
    e.lat = 1;
    case (o)
      0: begin e.q = x + y; c = (x + y >= m) ? 1 : 0; end
      1: begin e.q = (x - y + m) % m; br = (x < y) ? 1 : 0; end
      2: e.q = (m - 1) - (x ^ y);
      3: e.q = x / 2;
      4: begin e.q = x * y; e.lat = W; end
      5: begin
        if (y == 0) begin e.q = x * m + (m - 1); d = 1; end
        else begin e.q = (x % y) * m + (x / y); e.lat = W; end
      end
      default: begin e.q = 0; il = 1; end
    endcase
    e.flags = (c << 4) | (br << 3) | ((e.q == 0 ? 1 : 0) << 2) | (d << 1) | il;
    return e;
  endfunction

  task automatic runOp(input int o, input int x, input int y, input int holdCycles);
    expect_t e;
    int lat;
    e = model(o, x, y);
    op = 3'(o); a = W'(x); b = W'(y); in_valid = 1'b1; out_ready = 1'b0;
    checkVal("in_ready_idle", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      checkVal("in_ready_busy", 32'(in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    checkVal($sformatf("latency op%0d %0d,%0d", o, x, y), lat, e.lat);
    checkVal($sformatf("q op%0d %0d,%0d", o, x, y), 32'(q), e.q);
    checkVal($sformatf("flags op%0d %0d,%0d", o, x, y),
             32'({carry, borrow, zero, dbz, illegal}), e.flags);
    if (holdCycles > 0) begin
      repeat (holdCycles) begin @(posedge clk); #1; end
      checkVal("hold_q", 32'(q), e.q);
      checkVal("hold_out_valid", 32'(out_valid), 1);
      checkVal("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("after_take_out_valid", 32'(out_valid), 0);
    checkVal("after_take_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_out_valid", 32'(out_valid), 0);
    checkVal("reset_in_ready", 32'(in_ready), 1);
    checkVal("reset_q", 32'(q), 0);
    checkVal("reset_flags", 32'({carry, borrow, zero, dbz, illegal}), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    runOp(0, 3, 1, 0);
    runOp(0, 4, 7, 0);
    runOp(1, 4, 1, 0);
    runOp(1, 2, 5, 0);
    runOp(1, 7, 7, 0);
    runOp(2, 7, 6, 0);
    runOp(2, 2, 5, 0);
    runOp(3, 5, 0, 0);
    runOp(4, 7, 7, 0);
    runOp(5, 7, 2, 0);
    runOp(5, 5, 0, 0);
    runOp(6, 3, 3, 0);
    runOp(7, 0, 0, 0);
    runOp(4, 6, 5, 5);

    // Abort a MUL in its second BUSY cycle.
    op = 3'd4; a = 3'd7; b = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkVal("pre_abort_busy", 32'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    checkVal("abort_out_valid", 32'(out_valid), 0);
    checkVal("abort_in_ready", 32'(in_ready), 1);
    checkVal("abort_q", 32'(q), 0);
    checkVal("abort_flags", 32'({carry, borrow, zero, dbz, illegal}), 0);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checkVal("post_abort_no_result", 32'(out_valid), 0);
    end
    runOp(0, 3, 1, 0);

    for (int i = 0; i < 60; i++) begin
      runOp(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
